serial_add_arb: RTL and testbench

SERIAL_ADD_ARB -- requirements
Module: serial_add_arb

---
 rtl/serial_add_arb.sv | 155 +++++++++++++++
 tb/tb_serial_add_arb.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/serial_add_arb.sv
// Two-requester round-robin arbiter in front of a bit-serial adder (one full adder + carry flop).
// Optional SERIAL_ADD_ABORT_EN adds an abort input that cancels a running addition.
module serial_add_arb #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0,
    input  logic             req1,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] b0,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] b1,
`ifdef SERIAL_ADD_ABORT_EN
    input  logic             abort,
`endif
    output logic [1:0]       gnt,
    output logic             busy,
    output logic [WIDTH:0]   sum,
    output logic             sum_valid,
    output logic             sum_id
);

    localparam int unsigned CntW = $clog2(WIDTH + 1);
    localparam logic [CntW-1:0] LastBit = CntW'(WIDTH - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_sr_q, a_sr_d;
    logic [WIDTH-1:0] b_sr_q, b_sr_d;
    logic [WIDTH-1:0] sum_sr_q, sum_sr_d;
    logic             carry_q, carry_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             last_q, last_d;
    logic             owner_q, owner_d;
    logic [1:0]       gnt_q, gnt_d;
    logic             busy_q, busy_d;
    logic [WIDTH:0]   sum_q, sum_d;
    logic             sum_valid_q, sum_valid_d;
    logic             sum_id_q, sum_id_d;

    logic abort_w;
    logic win;
    logic ha1_s, ha1_c, ha2_s, ha2_c, carry_out;

`ifdef SERIAL_ADD_ABORT_EN
    assign abort_w = abort;
`else
    assign abort_w = 1'b0;
`endif

    // Full adder as two half-adder stages on the operand LSBs.
    assign ha1_s     = a_sr_q[0] ^ b_sr_q[0];
    assign ha1_c     = a_sr_q[0] & b_sr_q[0];
    assign ha2_s     = ha1_s ^ carry_q;
    assign ha2_c     = ha1_s & carry_q;
    assign carry_out = ha1_c | ha2_c;

    always_comb begin
        state_d     = state_q;
        a_sr_d      = a_sr_q;
        b_sr_d      = b_sr_q;
        sum_sr_d    = sum_sr_q;
        carry_d     = carry_q;
        cnt_d       = cnt_q;
        last_d      = last_q;
        owner_d     = owner_q;
        gnt_d       = 2'b00;
        sum_d       = sum_q;
        sum_valid_d = 1'b0;
        sum_id_d    = sum_id_q;
        win         = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (req0 || req1) begin
                    // On a tie the requester not served last wins.
                    win      = (req0 && req1) ? ~last_q : req1;
                    gnt_d    = win ? 2'b10 : 2'b01;
                    a_sr_d   = win ? a1 : a0;
                    b_sr_d   = win ? b1 : b0;
                    sum_sr_d = '0;
                    carry_d  = 1'b0;
                    cnt_d    = '0;
                    last_d   = win;
                    owner_d  = win;
                    state_d  = StRun;
                end
            end
            StRun: begin
                if (abort_w) begin
                    state_d = StIdle;
                end else begin
                    a_sr_d   = a_sr_q >> 1;
                    b_sr_d   = b_sr_q >> 1;
                    sum_sr_d = {ha2_s, sum_sr_q[WIDTH-1:1]};
                    carry_d  = carry_out;
                    cnt_d    = cnt_q + 1'b1;
                    if (cnt_q == LastBit) begin
                        state_d = StDone;
                    end
                end
            end
            StDone: begin
                sum_d       = {carry_q, sum_sr_q};
                sum_valid_d = 1'b1;
                sum_id_d    = owner_q;
                state_d     = StIdle;
            end
            default: state_d = StIdle;
        endcase

        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            a_sr_q      <= '0;
            b_sr_q      <= '0;
            sum_sr_q    <= '0;
            carry_q     <= 1'b0;
            cnt_q       <= '0;
            last_q      <= 1'b1;
            owner_q     <= 1'b0;
            gnt_q       <= 2'b00;
            busy_q      <= 1'b0;
            sum_q       <= '0;
            sum_valid_q <= 1'b0;
            sum_id_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_sr_q      <= a_sr_d;
            b_sr_q      <= b_sr_d;
            sum_sr_q    <= sum_sr_d;
            carry_q     <= carry_d;
            cnt_q       <= cnt_d;
            last_q      <= last_d;
            owner_q     <= owner_d;
            gnt_q       <= gnt_d;
            busy_q      <= busy_d;
            sum_q       <= sum_d;
            sum_valid_q <= sum_valid_d;
            sum_id_q    <= sum_id_d;
        end
    end

    assign gnt       = gnt_q;
    assign busy      = busy_q;
    assign sum       = sum_q;
    assign sum_valid = sum_valid_q;
    assign sum_id    = sum_id_q;

endmodule

// File: tb/tb_serial_add_arb.sv
// Scoreboard bench for serial_add_arb (WIDTH=8): stimulus pushes expected grants and sums,
// monitors pop and compare on gnt / sum_valid.
module tb_serial_add_arb;

    localparam int unsigned WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             req0 = 1'b0, req1 = 1'b0;
    logic [WIDTH-1:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
    logic [1:0]       gnt;
    logic             busy;
    logic [WIDTH:0]   sum;
    logic             sum_valid;
    logic             sum_id;
`ifdef SERIAL_ADD_ABORT_EN
    logic             abort = 1'b0;
`endif

    serial_add_arb #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req0      (req0),
        .req1      (req1),
        .a0        (a0),
        .b0        (b0),
        .a1        (a1),
        .b1        (b1),
`ifdef SERIAL_ADD_ABORT_EN
        .abort     (abort),
`endif
        .gnt       (gnt),
        .busy      (busy),
        .sum       (sum),
        .sum_valid (sum_valid),
        .sum_id    (sum_id)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [1:0]       exp_gnt_q[$];
    logic [WIDTH+1:0] exp_sum_q[$];   // {sum_id, sum}
    int               gnt_cyc_q[$];
    bit               spacing_en = 1'b0;
    bit               have_prev = 1'b0;
    int               prev_gnt_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Grant monitor
    always @(negedge clk) begin
        if (rst_n && gnt != 2'b00) begin
            if (exp_gnt_q.size() == 0) begin
                chk("unexpected_gnt", {30'd0, gnt}, 32'd0);
            end else begin
                chk("gnt", {30'd0, gnt}, {30'd0, exp_gnt_q.pop_front()});
            end
            if (spacing_en && have_prev) begin
                chk("gnt_spacing", cyc - prev_gnt_cyc, 32'd10);
            end
            have_prev    = 1'b1;
            prev_gnt_cyc = cyc;
            gnt_cyc_q.push_back(cyc);
        end
    end

    // Result monitor
    always @(negedge clk) begin
        if (rst_n && sum_valid) begin
            if (exp_sum_q.size() == 0) begin
                chk("unexpected_sum_valid", 32'd1, 32'd0);
            end else begin
                logic [WIDTH+1:0] e;
                e = exp_sum_q.pop_front();
                chk("sum", {23'd0, sum}, {23'd0, e[WIDTH:0]});
                chk("sum_id", {31'd0, sum_id}, {31'd0, e[WIDTH+1]});
            end
            if (gnt_cyc_q.size() != 0) begin
                chk("latency", cyc - gnt_cyc_q.pop_front(), WIDTH + 1);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_gnt(input logic [1:0] g);
        for (int i = 0; i < 40; i++) begin
            step();
            if (gnt == g) return;
        end
        chk("gnt_timeout", {30'd0, gnt}, {30'd0, g});
    endtask

    task automatic expect_op(input logic id, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                             input logic [WIDTH:0] s);
        exp_gnt_q.push_back(id ? 2'b10 : 2'b01);
        exp_sum_q.push_back({id, s});
        if (id) begin a1 = a; b1 = b; req1 = 1'b1; end
        else    begin a0 = a; b0 = b; req0 = 1'b1; end
    endtask

    task automatic wait_idle();
        for (int i = 0; i < WIDTH + 4; i++) step();
    endtask

    initial begin
        // Reset values
        #2;
        chk("rst_gnt", {30'd0, gnt}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_sum", {23'd0, sum}, 32'd0);
        chk("rst_sum_valid", {31'd0, sum_valid}, 32'd0);
        chk("rst_sum_id", {31'd0, sum_id}, 32'd0);
        step(); step();
        rst_n = 1'b1;
        step();

        // 0x00 + 0x00 on requester 0
        expect_op(1'b0, 8'h00, 8'h00, 9'h000);
        wait_gnt(2'b01);
        req0 = 1'b0;
        chk("busy_after_gnt", {31'd0, busy}, 32'd1);
        wait_idle();

        // 0xFF + 0x01 on requester 1, sum held after pulse
        expect_op(1'b1, 8'hFF, 8'h01, 9'h100);
        wait_gnt(2'b10);
        req1 = 1'b0;
        wait_idle();
        step(); step();
        chk("sum_hold", {23'd0, sum}, 32'h100);
        chk("sum_id_hold", {31'd0, sum_id}, 32'd1);
        chk("sum_valid_low", {31'd0, sum_valid}, 32'd0);

        // Both requesting: alternate 01,10,01 at 10-cycle spacing
        have_prev  = 1'b0;
        spacing_en = 1'b1;
        expect_op(1'b0, 8'h55, 8'hAA, 9'h0FF);
        expect_op(1'b1, 8'h80, 8'h80, 9'h100);
        exp_gnt_q.push_back(2'b01);
        exp_sum_q.push_back({1'b0, 9'h0FF});
        wait_gnt(2'b01);
        wait_gnt(2'b10);
        wait_gnt(2'b01);
        req0 = 1'b0;
        req1 = 1'b0;
        wait_idle();
        spacing_en = 1'b0;

        // Operand change after grant must not matter
        expect_op(1'b0, 8'h01, 8'h01, 9'h002);
        wait_gnt(2'b01);
        req0 = 1'b0;
        step();
        a0 = 8'hFF;
        wait_idle();

        // Reset four cycles into RUN: discard, then normal service
        exp_gnt_q.push_back(2'b01);
        a0 = 8'h03; b0 = 8'h04; req0 = 1'b1;
        wait_gnt(2'b01);
        req0 = 1'b0;
        for (int i = 0; i < 4; i++) step();
        rst_n = 1'b0;
        #1;
        chk("midrun_rst_gnt", {30'd0, gnt}, 32'd0);
        chk("midrun_rst_busy", {31'd0, busy}, 32'd0);
        chk("midrun_rst_sum", {23'd0, sum}, 32'd0);
        chk("midrun_rst_sum_id", {31'd0, sum_id}, 32'd0);
        gnt_cyc_q.delete();
        for (int i = 0; i < 12; i++) begin
            step();
            chk("no_valid_in_rst", {31'd0, sum_valid}, 32'd0);
        end
        rst_n = 1'b1;
        step();
        expect_op(1'b0, 8'h12, 8'h34, 9'h046);
        wait_gnt(2'b01);
        req0 = 1'b0;
        wait_idle();

`ifdef SERIAL_ADD_ABORT_EN
        // Abort in the third RUN cycle, pending req1 granted next
        exp_gnt_q.push_back(2'b01);
        a0 = 8'h01; b0 = 8'h01; req0 = 1'b1;
        wait_gnt(2'b01);
        req0 = 1'b0;
        expect_op(1'b1, 8'h10, 8'h20, 9'h030);
        step();
        step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_sum_kept", {23'd0, sum}, 32'h046);
        void'(gnt_cyc_q.pop_front());
        step();
        chk("abort_next_gnt", {30'd0, gnt}, 32'd2);
        req1 = 1'b0;
        wait_idle();
`endif

        wait_idle();
        chk("gnt_queue_drained", exp_gnt_q.size(), 32'd0);
        chk("sum_queue_drained", exp_sum_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
